// File: rtl/qos_egress_arbiter.sv
// qos_egress_arbiter: merges per-class FIFOs P0..P3 into one egress stream and keeps word counters.
// Build option STRICT_PRIORITY_EN selects fixed priority P0 > P1 > P2 > P3 instead of round-robin.
module qos_egress_arbiter #(
  parameter int DW = 12,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    fifo_empty,
  input  logic [DW-1:0] fifo_dataout0,
  input  logic [DW-1:0] fifo_dataout1,
  input  logic [DW-1:0] fifo_dataout2,
  input  logic [DW-1:0] fifo_dataout3,
  output logic          pop0,
  output logic          pop1,
  output logic          pop2,
  output logic          pop3,
  input  logic          out_almost_full,
  output logic          push_out,
  output logic [DW-1:0] data_out,
  input  logic          req,
  input  logic [2:0]    idx,
  output logic          valid,
  output logic [CW-1:0] data,
  output logic          idle_out,
  output logic          active_out
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          idle_q, idle_d;
  logic          active_q, active_d;
  logic [3:0]    pop_q, pop_d;
  logic [1:0]    sel1_q;
  logic          v2_q;
  logic [1:0]    sel2_q;
  logic          push_q;
  logic [DW-1:0] data_out_q, data_out_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] total_q;
  logic          valid_q;
  logic [CW-1:0] data_q, data_d;
  logic          grant_vld;
  logic [1:0]    grant_idx;
  logic [1:0]    push_cls;

`ifdef STRICT_PRIORITY_EN
  // Fixed priority: the lowest-numbered non-empty class wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!fifo_empty[k]) begin
        grant_vld = 1'b1;
        grant_idx = 2'(k);
      end else begin
        grant_vld = grant_vld;
      end
    end
  end
`else
  logic [1:0] rr_q, rr_d;
  logic [1:0] cand;

  // Round-robin search from rr_q; scanning backwards lets the nearest candidate win.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_q + 2'(k);
      if (!fifo_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end else begin
        grant_vld = grant_vld;
      end
    end
  end

  assign rr_d = (|pop_d) ? (grant_idx + 2'd1) : rr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q <= 2'd0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign pop_d = (grant_vld && !out_almost_full) ? (4'b0001 << grant_idx) : 4'b0000;

  // Returned FIFO word is selected by the class popped one cycle earlier.
  always_comb begin
    case (sel2_q)
      2'd0:    data_out_d = fifo_dataout0;
      2'd1:    data_out_d = fifo_dataout1;
      2'd2:    data_out_d = fifo_dataout2;
      2'd3:    data_out_d = fifo_dataout3;
      default: data_out_d = fifo_dataout0;
    endcase
  end

  // Pop -> FIFO read -> push pipeline; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_q      <= 4'b0000;
      sel1_q     <= 2'd0;
      v2_q       <= 1'b0;
      sel2_q     <= 2'd0;
      push_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      pop_q      <= pop_d;
      sel1_q     <= grant_idx;
      v2_q       <= |pop_q;
      sel2_q     <= sel1_q;
      push_q     <= v2_q;
      data_out_q <= v2_q ? data_out_d : '0;
    end
  end

  assign push_cls = data_out_q[DW-1 -: 2];

  always_comb begin
    data_d = '0;
    if (req) begin
      case (idx)
        3'd0:    data_d = cnt_q[0];
        3'd1:    data_d = cnt_q[1];
        3'd2:    data_d = cnt_q[2];
        3'd3:    data_d = cnt_q[3];
        3'd4:    data_d = total_q;
        default: data_d = '0;
      endcase
    end else begin
      data_d = '0;
    end
  end

  // Counters count on the registered push; a read sees the pre-increment value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      total_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (push_q) begin
        cnt_q[push_cls] <= cnt_q[push_cls] + CW'(1);
        total_q         <= total_q + CW'(1);
      end
      valid_q <= req;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idle_q   <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!(&fifo_empty)) state_d = ST_ACTIVE;
        else                state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if ((&fifo_empty) && !(|pop_q) && !v2_q) state_d = ST_IDLE;
        else                                     state_d = ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idle_d   = (state_d == ST_IDLE);
    active_d = (state_d == ST_ACTIVE);
  end

  assign pop0       = pop_q[0];
  assign pop1       = pop_q[1];
  assign pop2       = pop_q[2];
  assign pop3       = pop_q[3];
  assign push_out   = push_q;
  assign data_out   = data_out_q;
  assign valid      = valid_q;
  assign data       = data_q;
  assign idle_out   = idle_q;
  assign active_out = active_q;

endmodule

// File: tb/tb_qos_egress_arbiter.sv
// Scoreboard bench for qos_egress_arbiter: queue-based FIFO responders, a grant-order model and counter model.
module tb_qos_egress_arbiter;
  localparam int DW = 12;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [3:0]    fifo_empty;
  logic [DW-1:0] dout [4];
  logic          pop0, pop1, pop2, pop3;
  logic          out_almost_full;
  logic          push_out;
  logic [DW-1:0] data_out;
  logic          req;
  logic [2:0]    idx;
  logic          valid;
  logic [CW-1:0] data;
  logic          idle_out, active_out;
  logic [3:0]    pop_vec;

  assign pop_vec = {pop3, pop2, pop1, pop0};

  qos_egress_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_dataout0(dout[0]), .fifo_dataout1(dout[1]),
    .fifo_dataout2(dout[2]), .fifo_dataout3(dout[3]),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .out_almost_full(out_almost_full), .push_out(push_out), .data_out(data_out),
    .req(req), .idx(idx), .valid(valid), .data(data),
    .idle_out(idle_out), .active_out(active_out)
  );

  int checks = 0;
  int passes = 0;

  int            fcnt [4];
  logic [DW-1:0] fq [4][$];
  logic [DW-1:0] mq [4][$];
  logic [DW-1:0] sbq [$];
  logic [3:0]    exp_pop = 4'b0000;
  int            ptr = 0;
  logic [CW-1:0] mcnt [4];
  logic [CW-1:0] mtot;
  logic          rd_pend_v = 1'b0;
  logic [CW-1:0] rd_pend_d = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
  endfunction

  function automatic logic [CW-1:0] model_read(logic [2:0] i);
    if (i < 3'd4)       return mcnt[i[1:0]];
    else if (i == 3'd4) return mtot;
    else                return '0;
  endfunction

  // FIFO empty looks ahead over the pop currently being presented.
  always_comb begin
    for (int i = 0; i < 4; i++) fifo_empty[i] = ((fcnt[i] - int'(pop_vec[i])) <= 0);
  end

  // FIFO responders: a pop seen at an edge returns its word for the following cycle.
  always @(posedge clk) begin
    logic [DW-1:0] w;
    for (int i = 0; i < 4; i++) begin
      if (pop_vec[i]) begin
        if (fq[i].size() == 0) begin
          checks++;
          $display("FAIL fifo_underflow: class %0d popped while empty", i);
        end else begin
          w = fq[i].pop_front();
          dout[i] <= w;
          fcnt[i] <= fcnt[i] - 1;
        end
      end
    end
  end

  // Grant model: first non-empty class from the pointer (or from P0 under strict priority).
  always @(posedge clk) begin
    int  g;
    int  c;
    bit  found;
    exp_pop = 4'b0000;
    if (reset !== 1'b1) begin
      ptr = 0;
    end else if (out_almost_full !== 1'b1) begin
      found = 1'b0;
      g = 0;
      for (int k = 0; k < 4; k++) begin
`ifdef STRICT_PRIORITY_EN
        c = k;
`else
        c = (ptr + k) % 4;
`endif
        if (!found && !fifo_empty[c]) begin
          found = 1'b1;
          g = c;
        end
      end
      if (found && mq[g].size() > 0) begin
        exp_pop[g] = 1'b1;
        ptr = (g + 1) % 4;
        sbq.push_back(mq[g].pop_front());
      end
    end
  end

  // Monitor: reads, pops and pushes compared against the model half a cycle after each edge.
  always @(negedge clk) begin
    logic [DW-1:0] w;
    if (reset !== 1'b1) begin
      sbq.delete();
      rd_pend_v = 1'b0;
      rd_pend_d = '0;
      mtot = '0;
      for (int i = 0; i < 4; i++) mcnt[i] = '0;
    end else begin
      if (valid || rd_pend_v) begin
        check("rd_valid", 32'(valid), 32'(rd_pend_v));
        if (rd_pend_v) check("rd_data", 32'(data), 32'(rd_pend_d));
      end
      rd_pend_v = req;
      rd_pend_d = req ? model_read(idx) : '0;
      if (pop_vec != 4'b0000 || exp_pop != 4'b0000) check("pop_vec", 32'(pop_vec), 32'(exp_pop));
      if (push_out) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL push_unexpected: data_out 'h%0h with nothing expected", data_out);
        end else begin
          w = sbq.pop_front();
          check("data_out", 32'(data_out), 32'(w));
          mcnt[w[DW-1 -: 2]] = mcnt[w[DW-1 -: 2]] + 8'd1;
          mtot = mtot + 8'd1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int c, logic [DW-1:0] w);
    fq[c].push_back(w);
    mq[c].push_back(w);
    fcnt[c] = fcnt[c] + 1;
  endtask

  task automatic read(logic [2:0] i);
    req = 1'b1;
    idx = i;
    step();
    req = 1'b0;
  endtask

  task automatic drain(int maxc);
    int n;
    n = 0;
    while ((sbq.size() != 0 || fcnt[0] != 0 || fcnt[1] != 0 || fcnt[2] != 0 || fcnt[3] != 0 ||
            idle_out !== 1'b1) && n < maxc) begin
      step();
      n++;
    end
    check("drain_sb_empty", 32'(sbq.size()), 32'd0);
    check("drain_idle", 32'(idle_out), 32'd1);
    check("drain_active", 32'(active_out), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    out_almost_full = 1'b0;
    req = 1'b0;
    idx = 3'd0;
    repeat (2) step();
    reset = 1'b1;
    check("rst_push", 32'(push_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_idle", 32'(idle_out), 32'd1);
    check("rst_active", 32'(active_out), 32'd0);
    check("rst_pops", 32'(pop_vec), 32'd0);
    repeat (3) step();
    check("idle_no_pops", 32'(pop_vec), 32'd0);

    // Single class, four words of mixed data class.
    load(0, 12'h0FF); load(0, 12'h404); load(0, 12'h895); load(0, 12'hCAE);
    step();
    check("went_active", 32'(active_out), 32'd1);
    drain(50);

    // All four classes loaded at once: RR order, then counter reads.
    pulse_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) load(i, {4'(i * 4 + j), 8'h5A});
    drain(100);
    for (int i = 0; i < 5; i++) read(3'(i));
    read(3'd6);
    repeat (2) step();

    // Backpressure in the middle of a burst.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) load(i, 12'($urandom));
    repeat (3) step();
    out_almost_full = 1'b1;
    repeat (6) step();
    out_almost_full = 1'b0;
    drain(100);

    // Randomized traffic, backpressure and counter reads.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(2, 0) == 0) load(int'($urandom_range(3, 0)), 12'($urandom));
      out_almost_full = ($urandom_range(3, 0) == 0);
      req = ($urandom_range(2, 0) == 0);
      idx = 3'($urandom_range(7, 0));
      step();
    end
    out_almost_full = 1'b0;
    req = 1'b0;
    drain(600);

    // Counter wrap: 257 words of class 2.
    pulse_reset();
    for (int n = 0; n < 257; n++) load(2, {2'b10, 10'($urandom)});
    drain(700);
    read(3'd2);
    read(3'd4);
    read(3'd0);
    repeat (2) step();

    // Reset with two words in flight: nothing may be pushed, counters clear.
    load(1, 12'h4A1);
    load(1, 12'h5B2);
    step();
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    check("rst_inflight_push", 32'(push_out), 32'd0);
    check("rst_inflight_pop", 32'(pop_vec), 32'd0);
    step();
    @(negedge clk);
    check("rst_inflight_push2", 32'(push_out), 32'd0);
    step();
    reset = 1'b1;
    repeat (4) step();
    check("fifo1_level", 32'(fcnt[1]), 32'd0);
    for (int i = 0; i < 5; i++) read(3'(i));
    repeat (2) step();
    drain(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
